// File: rtl/arb_pkg.sv
// Shared arbiter definitions: requester count, select width and FSM state type.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mux4.sv
// Generic 4-input parameterized multiplexer.
// Ports: in0..in3 data inputs, sel 2-bit select, out selected data (combinational).
module mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      default: out = in3;
    endcase
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with data mux.
// One registered grant is held until the downstream accepts it (out_ready),
// then the next edge re-arbitrates with the last winner ranked lowest.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req[3:0]              per-requester request
//   in0..in3              requester data
//   out_ready             downstream accepts out_data this cycle
//   lock                  (only with RR_ARB_LOCK_EN) keep current winner on transfer
//   grant[3:0], sel[1:0]  registered one-hot grant and its index
//   out_valid, out_data   grant held / data of the granted requester (0 when idle)
//   ack[3:0]              grant qualified by out_ready
// Build option: define RR_ARB_LOCK_EN to add the lock input.
module rr_mux_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic               out_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [NUM_REQ-1:0] ack
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   winner;
  logic               rearb;
  logic [WIDTH-1:0]   mux_out;

  // First requester in order last+1, last+2, last+3, last; returns last if none.
  // Scanning from the farthest position down lets the nearest hit overwrite.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   l);
    logic [SEL_W-1:0] idx;
    rr_pick = l;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = l + SEL_W'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // State and grant registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Next-state: arbitrate when idle or when the held grant transfers
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rearb   = 1'b0;
    winner  = rr_pick(req, last_q);

    case (state_q)
      IDLE:    rearb = 1'b1;
      BUSY:    rearb = out_ready;
      default: rearb = 1'b1;
    endcase

`ifdef RR_ARB_LOCK_EN
    // Locked transfer: the owner keeps the grant and the pointer stays put
    if (state_q == BUSY && out_ready && lock && req[sel_q]) rearb = 1'b0;
`endif

    if (rearb) begin
      if (|req) begin
        state_d = BUSY;
        grant_d = NUM_REQ'(1) << winner;
        sel_d   = winner;
        last_d  = winner;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    end
  end

  mux4 #(.WIDTH(WIDTH)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (sel_q),
    .out (mux_out)
  );

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = (state_q == BUSY);
  assign out_data  = out_valid ? mux_out : '0;
  // Reset discards the in-flight grant, so no ack is issued on a reset edge
  assign ack       = grant_q & {NUM_REQ{out_ready & ~reset}};

endmodule
